// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ----------------
// Decode-to-execute pipeline register. It resolves the two ALU operands
// (register / immediate / PC selection, plus optional MEM/WB bypass) and
// captures them together with the ALU operation and writeback tags on each
// accepted handshake.
//
// Compile-time option:
//   FORWARDING_EN  - when defined, rs1/rs2 are bypassed from the MEM stage
//                    (highest priority) and then the WB stage. When undefined,
//                    the i_fwd* ports are ignored and the register-file data
//                    is used as-is, because upstream interlock resolves hazards.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), async active-low reset
//   i_valid / o_ready       upstream handshake (o_ready = ~o_valid | i_ready)
//   i_op, i_pc              ALU operation and instruction address
//   i_rs1Addr/i_rs2Addr     source register indices
//   i_rs1Data/i_rs2Data     register-file read data
//   i_imm                   sign-extended immediate
//   i_selPC / i_selImm      operand A = pc, operand B = imm
//   i_rdAddr/i_regWrEnable  writeback destination and enable
//   i_fwdMem*/i_fwdWb*      bypass sources (used only with FORWARDING_EN)
//   i_flush                 drop held and incoming instruction
//   o_valid / i_ready       downstream handshake
//   o_op, o_dataA, o_dataB  ALU operation and operands
//   o_storeData             resolved rs2 (store data)
//   o_pc, o_rdAddr, o_regWrEnable  registered copies
//
// The ALU operation encoding is OP_WIDTH bits wide; encoding 0 is ADD.

module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [OP_WIDTH-1:0]       i_op,
    input  logic [DATA_WIDTH-1:0]     i_pc,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1Addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2Addr,
    input  logic [DATA_WIDTH-1:0]     i_rs1Data,
    input  logic [DATA_WIDTH-1:0]     i_rs2Data,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic                      i_selPC,
    input  logic                      i_selImm,
    input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr,
    input  logic                      i_regWrEnable,
    input  logic                      i_fwdMemEnable,
    input  logic                      i_fwdWbEnable,
    input  logic [REG_ADDR_WIDTH-1:0] i_fwdMemAddr,
    input  logic [REG_ADDR_WIDTH-1:0] i_fwdWbAddr,
    input  logic [DATA_WIDTH-1:0]     i_fwdMemData,
    input  logic [DATA_WIDTH-1:0]     i_fwdWbData,
    input  logic                      i_flush,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [OP_WIDTH-1:0]       o_op,
    output logic [DATA_WIDTH-1:0]     o_dataA,
    output logic [DATA_WIDTH-1:0]     o_dataB,
    output logic [DATA_WIDTH-1:0]     o_storeData,
    output logic [DATA_WIDTH-1:0]     o_pc,
    output logic [REG_ADDR_WIDTH-1:0] o_rdAddr,
    output logic                      o_regWrEnable
);

    localparam logic [OP_WIDTH-1:0]       ALU_OP_ADD = {OP_WIDTH{1'b0}};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO   = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     DATA_ZERO  = {DATA_WIDTH{1'b0}};

    logic                      valid_r;
    logic [OP_WIDTH-1:0]       op_r;
    logic [DATA_WIDTH-1:0]     data_a_r;
    logic [DATA_WIDTH-1:0]     data_b_r;
    logic [DATA_WIDTH-1:0]     store_data_r;
    logic [DATA_WIDTH-1:0]     pc_r;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
    logic                      reg_wr_en_r;

    logic                      ready_s;
    logic                      accept_s;
    logic [DATA_WIDTH-1:0]     rs1_res_s;
    logic [DATA_WIDTH-1:0]     rs2_res_s;
    logic [DATA_WIDTH-1:0]     op_a_s;
    logic [DATA_WIDTH-1:0]     op_b_s;

    // A held instruction blocks new input only while downstream stalls.
    assign ready_s  = ~valid_r | i_ready;
    assign accept_s = i_valid & ready_s;

`ifdef FORWARDING_EN
    // Bypass resolution: MEM beats WB; index 0 is hard-wired and never bypassed.
    always_comb begin
        rs1_res_s = i_rs1Data;
        rs2_res_s = i_rs2Data;
        if (i_fwdMemEnable && (i_fwdMemAddr == i_rs1Addr) && (i_rs1Addr != REG_ZERO)) begin
            rs1_res_s = i_fwdMemData;
        end else if (i_fwdWbEnable && (i_fwdWbAddr == i_rs1Addr) && (i_rs1Addr != REG_ZERO)) begin
            rs1_res_s = i_fwdWbData;
        end else begin
            rs1_res_s = i_rs1Data;
        end
        if (i_fwdMemEnable && (i_fwdMemAddr == i_rs2Addr) && (i_rs2Addr != REG_ZERO)) begin
            rs2_res_s = i_fwdMemData;
        end else if (i_fwdWbEnable && (i_fwdWbAddr == i_rs2Addr) && (i_rs2Addr != REG_ZERO)) begin
            rs2_res_s = i_fwdWbData;
        end else begin
            rs2_res_s = i_rs2Data;
        end
    end
`else
    logic unused_fwd_s;

    // Without bypass the register-file data is already correct; bypass ports are sunk.
    always_comb begin
        rs1_res_s   = i_rs1Data;
        rs2_res_s   = i_rs2Data;
        unused_fwd_s = ^{i_fwdMemEnable, i_fwdWbEnable, i_fwdMemAddr, i_fwdWbAddr,
                         i_fwdMemData, i_fwdWbData, i_rs1Addr, i_rs2Addr};
    end
`endif

    // Operand selection; store data always takes resolved rs2.
    always_comb begin
        op_a_s = rs1_res_s;
        op_b_s = rs2_res_s;
        if (i_selPC) begin
            op_a_s = i_pc;
        end else begin
            op_a_s = rs1_res_s;
        end
        if (i_selImm) begin
            op_b_s = i_imm;
        end else begin
            op_b_s = rs2_res_s;
        end
    end

    // Pipeline register: flush beats accept; flush leaves the data registers untouched.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_r      <= 1'b0;
            op_r         <= ALU_OP_ADD;
            data_a_r     <= DATA_ZERO;
            data_b_r     <= DATA_ZERO;
            store_data_r <= DATA_ZERO;
            pc_r         <= DATA_ZERO;
            rd_addr_r    <= REG_ZERO;
            reg_wr_en_r  <= 1'b0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r      <= 1'b1;
            op_r         <= i_op;
            data_a_r     <= op_a_s;
            data_b_r     <= op_b_s;
            store_data_r <= rs2_res_s;
            pc_r         <= i_pc;
            rd_addr_r    <= i_rdAddr;
            reg_wr_en_r  <= i_regWrEnable;
        end else if (i_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign o_ready       = ready_s;
    assign o_valid       = valid_r;
    assign o_op          = op_r;
    assign o_dataA       = data_a_r;
    assign o_dataB       = data_b_r;
    assign o_storeData   = store_data_r;
    assign o_pc          = pc_r;
    assign o_rdAddr      = rd_addr_r;
    assign o_regWrEnable = reg_wr_en_r;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage. Inputs change 1 ns after the
// rising edge; outputs are checked at that same point, well away from the edge.
`timescale 1ns/1ps

module tb_ex_operand_stage;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic [31:0] i_pc;
    logic [4:0]  i_rs1Addr, i_rs2Addr;
    logic [31:0] i_rs1Data, i_rs2Data, i_imm;
    logic        i_selPC, i_selImm;
    logic [4:0]  i_rdAddr;
    logic        i_regWrEnable;
    logic        i_fwdMemEnable, i_fwdWbEnable;
    logic [4:0]  i_fwdMemAddr, i_fwdWbAddr;
    logic [31:0] i_fwdMemData, i_fwdWbData;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_op;
    logic [31:0] o_dataA, o_dataB, o_storeData, o_pc;
    logic [4:0]  o_rdAddr;
    logic        o_regWrEnable;

    int checks   = 0;
    int failures = 0;

    always #5 i_clock = ~i_clock;

    ex_operand_stage dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_pc(i_pc), .i_rs1Addr(i_rs1Addr), .i_rs2Addr(i_rs2Addr),
        .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data), .i_imm(i_imm),
        .i_selPC(i_selPC), .i_selImm(i_selImm), .i_rdAddr(i_rdAddr),
        .i_regWrEnable(i_regWrEnable), .i_fwdMemEnable(i_fwdMemEnable),
        .i_fwdWbEnable(i_fwdWbEnable), .i_fwdMemAddr(i_fwdMemAddr),
        .i_fwdWbAddr(i_fwdWbAddr), .i_fwdMemData(i_fwdMemData),
        .i_fwdWbData(i_fwdWbData), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_op(o_op), .o_dataA(o_dataA), .o_dataB(o_dataB),
        .o_storeData(o_storeData), .o_pc(o_pc), .o_rdAddr(o_rdAddr),
        .o_regWrEnable(o_regWrEnable)
    );

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Present one instruction with bypasses disabled.
    task automatic drive(input logic [3:0] op, input logic [31:0] pc,
                         input logic [4:0] rs1a, input logic [4:0] rs2a,
                         input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic selpc, input logic selimm,
                         input logic [4:0] rd, input logic we);
        i_valid = 1'b1; i_op = op; i_pc = pc;
        i_rs1Addr = rs1a; i_rs2Addr = rs2a; i_rs1Data = rs1d; i_rs2Data = rs2d;
        i_imm = imm; i_selPC = selpc; i_selImm = selimm;
        i_rdAddr = rd; i_regWrEnable = we;
        i_fwdMemEnable = 1'b0; i_fwdWbEnable = 1'b0;
        i_fwdMemAddr = 5'd0; i_fwdWbAddr = 5'd0;
        i_fwdMemData = 32'd0; i_fwdWbData = 32'd0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        drive(4'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        i_valid = 1'b0;
        #3;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        checks++; if (o_regWrEnable !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", o_regWrEnable); end
        checks++; if (o_op !== 4'd0) begin failures++; $display("FAIL reset_op got=%0h exp=0", o_op); end
        checks++; if ({o_dataA, o_dataB, o_storeData, o_pc, o_rdAddr} !== 133'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", {o_dataA, o_dataB, o_storeData, o_pc, o_rdAddr}); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", o_ready); end
        @(negedge i_clock); i_reset = 1'b1;
        tick();
        // Mid-stream: load an instruction, then assert reset between edges.
        drive(4'd5, 32'h40, 5'd1, 5'd2, 32'h77, 32'h88, 32'd0, 1'b0, 1'b0, 5'd9, 1'b1);
        tick();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%0h exp=1", o_valid); end
        i_valid = 1'b0; i_ready = 1'b0;
        #2; i_reset = 1'b0; #1;
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%0h exp=0", o_valid); end
        checks++; if (o_regWrEnable !== 1'b0) begin failures++; $display("FAIL midreset_we got=%0h exp=0", o_regWrEnable); end
        checks++; if (o_op !== 4'd0) begin failures++; $display("FAIL midreset_op got=%0h exp=0", o_op); end
        @(negedge i_clock); i_reset = 1'b1; i_ready = 1'b1;
        drive(4'd3, 32'h44, 5'd1, 5'd2, 32'h12, 32'h34, 32'd0, 1'b0, 1'b0, 5'd4, 1'b1);
        tick();
        checks++; if (o_valid !== 1'b1 || o_dataA !== 32'h12 || o_op !== 4'd3) begin failures++; $display("FAIL post_reset_accept got v=%0h a=%0h op=%0h exp v=1 a=12 op=3", o_valid, o_dataA, o_op); end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_imm_path();
        drive(4'd0, 32'h100, 5'd1, 5'd2, 32'd5, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd7, 1'b1);
        tick();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL imm_valid got=%0h exp=1", o_valid); end
        checks++; if (o_dataA !== 32'd5) begin failures++; $display("FAIL imm_dataA got=%0h exp=5", o_dataA); end
        checks++; if (o_dataB !== 32'hFFFF_FFFF) begin failures++; $display("FAIL imm_dataB got=%0h exp=ffffffff", o_dataB); end
        checks++; if (o_storeData !== 32'h1234) begin failures++; $display("FAIL imm_store got=%0h exp=1234", o_storeData); end
        checks++; if (o_pc !== 32'h100 || o_rdAddr !== 5'd7 || o_regWrEnable !== 1'b1 || o_op !== 4'd0) begin failures++; $display("FAIL imm_tags got pc=%0h rd=%0h we=%0h op=%0h exp 100/7/1/0", o_pc, o_rdAddr, o_regWrEnable, o_op); end
        // PC as operand A, register operand B.
        drive(4'd2, 32'h200, 5'd1, 5'd2, 32'd9, 32'h33, 32'h55, 1'b1, 1'b0, 5'd8, 1'b0);
        tick();
        checks++; if (o_dataA !== 32'h200 || o_dataB !== 32'h33) begin failures++; $display("FAIL selpc got a=%0h b=%0h exp a=200 b=33", o_dataA, o_dataB); end
        checks++; if (o_regWrEnable !== 1'b0 || o_op !== 4'd2) begin failures++; $display("FAIL selpc_tags got we=%0h op=%0h exp we=0 op=2", o_regWrEnable, o_op); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        // Both sources match rs1 = 3: MEM has priority.
        drive(4'd0, 32'h0, 5'd3, 5'd6, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b0, 5'd1, 1'b1);
        i_fwdMemEnable = 1'b1; i_fwdMemAddr = 5'd3; i_fwdMemData = 32'h11;
        i_fwdWbEnable  = 1'b1; i_fwdWbAddr  = 5'd3; i_fwdWbData  = 32'h22;
`ifdef FORWARDING_EN
        exp_a = 32'h11;
`else
        exp_a = 32'hAA;
`endif
        tick();
        checks++; if (o_dataA !== exp_a) begin failures++; $display("FAIL bypass_prio got=%0h exp=%0h", o_dataA, exp_a); end
        checks++; if (o_dataB !== 32'hBB) begin failures++; $display("FAIL bypass_nomatch got=%0h exp=bb", o_dataB); end
        // Register 0 is never bypassed, even if both sources name it.
        drive(4'd0, 32'h0, 5'd0, 5'd0, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b0, 5'd1, 1'b1);
        i_fwdMemEnable = 1'b1; i_fwdMemAddr = 5'd0; i_fwdMemData = 32'h11;
        i_fwdWbEnable  = 1'b1; i_fwdWbAddr  = 5'd0; i_fwdWbData  = 32'h22;
        tick();
        checks++; if (o_dataA !== 32'hAA || o_dataB !== 32'hBB) begin failures++; $display("FAIL bypass_x0 got a=%0h b=%0h exp a=aa b=bb", o_dataA, o_dataB); end
        // WB only matches rs2; disabled MEM naming rs2 must be ignored.
        drive(4'd0, 32'h0, 5'd1, 5'd4, 32'hAA, 32'hBB, 32'h99, 1'b0, 1'b1, 5'd1, 1'b1);
        i_fwdMemEnable = 1'b0; i_fwdMemAddr = 5'd4; i_fwdMemData = 32'h11;
        i_fwdWbEnable  = 1'b1; i_fwdWbAddr  = 5'd4; i_fwdWbData  = 32'h22;
`ifdef FORWARDING_EN
        exp_b = 32'h22;
`else
        exp_b = 32'hBB;
`endif
        tick();
        checks++; if (o_storeData !== exp_b) begin failures++; $display("FAIL bypass_wb_store got=%0h exp=%0h", o_storeData, exp_b); end
        checks++; if (o_dataB !== 32'h99 || o_dataA !== 32'hAA) begin failures++; $display("FAIL bypass_wb_ops got a=%0h b=%0h exp a=aa b=99", o_dataA, o_dataB); end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        drive(4'd1, 32'hA0, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1);
        i_ready = 1'b1;
        tick();
        drive(4'd6, 32'hB0, 5'd1, 5'd2, 32'hB1, 32'hB2, 32'd0, 1'b0, 1'b0, 5'd11, 1'b0);
        i_ready = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0h exp=0", o_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_valid !== 1'b1 || o_dataA !== 32'hA1 || o_pc !== 32'hA0 || o_op !== 4'd1 || o_rdAddr !== 5'd10) begin failures++; $display("FAIL stall_hold%0d got v=%0h a=%0h pc=%0h op=%0h rd=%0h exp 1/a1/a0/1/a", i, o_valid, o_dataA, o_pc, o_op, o_rdAddr); end
        end
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0h exp=1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_dataA !== 32'hB1 || o_storeData !== 32'hB2 || o_op !== 4'd6) begin failures++; $display("FAIL stall_B got v=%0h a=%0h s=%0h op=%0h exp 1/b1/b2/6", o_valid, o_dataA, o_storeData, o_op); end
        i_valid = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", o_valid); end
    endtask

    task automatic test_flush();
        drive(4'd1, 32'hA0, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1);
        i_ready = 1'b1;
        tick();
        // A held, C offered with flush.
        drive(4'd7, 32'hC0, 5'd1, 5'd2, 32'hC1, 32'hC2, 32'd0, 1'b0, 1'b0, 5'd12, 1'b1);
        i_ready = 1'b0; i_flush = 1'b1;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_held_valid got=%0h exp=0", o_valid); end
        checks++; if (o_dataA !== 32'hA1) begin failures++; $display("FAIL flush_held_data got=%0h exp=a1", o_dataA); end
        // Empty stage: handshake accepts C but flush drops it.
        #1;
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_dataA !== 32'hA1 || o_pc !== 32'hA0) begin failures++; $display("FAIL flush_accept got v=%0h a=%0h pc=%0h exp 0/a1/a0", o_valid, o_dataA, o_pc); end
        i_flush = 1'b0; i_ready = 1'b1;
        drive(4'd4, 32'hD0, 5'd1, 5'd2, 32'hD1, 32'hD2, 32'd0, 1'b0, 1'b0, 5'd13, 1'b1);
        tick();
        checks++; if (o_valid !== 1'b1 || o_dataA !== 32'hD1) begin failures++; $display("FAIL after_flush got v=%0h a=%0h exp 1/d1", o_valid, o_dataA); end
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(4'(i + 1), 32'(32'h1000 + i * 4), 5'd1, 5'd2, 32'(32'h500 + i), 32'(32'h600 + i),
                  32'd0, 1'b0, 1'b0, 5'(i + 1), 1'b1);
            tick();
            checks++; if (o_valid !== 1'b1 || o_dataA !== 32'(32'h500 + i) || o_dataB !== 32'(32'h600 + i) || o_rdAddr !== 5'(i + 1)) begin failures++; $display("FAIL b2b%0d got v=%0h a=%0h b=%0h rd=%0h", i, o_valid, o_dataA, o_dataB, o_rdAddr); end
        end
        i_valid = 1'b0;
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_imm_path();
        test_bypass();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Decode-to-execute pipeline register that resolves the ALU operands and feeds the ALU. Each accepted instruction is captured in one cycle; the output presents the resolved operands, ALU operation and writeback tags to the ALU and the EX/MEM stage. Operand resolution covers register/immediate/PC selection and, optionally, bypass from MEM and WB. The stage has a valid/ready handshake on both sides and a flush input for branch redirects and traps.

## Interface
- DATA_WIDTH, 32: operand width, equal to $size(Data).
- REG_ADDR_WIDTH, 5: register index width.

- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  decode presents an instruction.
- o_ready  out  1  stage can accept this cycle.
- i_op  in  AluOp  ALU operation.
- i_pc  in  DATA_WIDTH  instruction address.
- i_rs1Addr, i_rs2Addr  in  REG_ADDR_WIDTH  source indices.
- i_rs1Data, i_rs2Data  in  DATA_WIDTH  register-file read data.
- i_imm  in  DATA_WIDTH  sign-extended immediate.
- i_selPC  in  1  operand A = i_pc instead of rs1.
- i_selImm  in  1  operand B = i_imm instead of rs2.
- i_rdAddr  in  REG_ADDR_WIDTH  destination index.
- i_regWrEnable  in  1  instruction writes rd.
- i_fwdMemEnable, i_fwdWbEnable  in  1  bypass source valid.
- i_fwdMemAddr, i_fwdWbAddr  in  REG_ADDR_WIDTH  bypass destination.
- i_fwdMemData, i_fwdWbData  in  DATA_WIDTH  bypass value.
- i_flush  in  1  discard held and incoming instruction.
- o_valid  out  1  outputs hold a live instruction.
- i_ready  in  1  downstream accepts this cycle.
- o_op  out  AluOp; o_dataA, o_dataB  out  DATA_WIDTH  ALU operands.
- o_storeData  out  DATA_WIDTH  resolved rs2, used for stores.
- o_pc, o_rdAddr, o_regWrEnable: registered copies.

## Operation
- Throughout, accept = i_valid & o_ready, and o_ready = ~o_valid | i_ready.
- rs1 resolution uses this priority: MEM bypass if i_fwdMemEnable, i_fwdMemAddr == i_rs1Addr and i_rs1Addr != 0; otherwise WB bypass under the same rule; otherwise i_rs1Data. rs2 is resolved the same way.
- Index 0 always resolves to i_rsXData and is never bypassed.
- Operand A = i_selPC ? i_pc : resolved rs1.
- Operand B = i_selImm ? i_imm : resolved rs2.
- o_storeData = resolved rs2, regardless of i_selImm.
- Resolution is combinational on the inputs. It is sampled only on an accept edge, and held outputs never change while stalled.
- Register update on each edge:
  - i_flush: o_valid <= 0; data registers unchanged.
  - else accept: load all outputs; o_valid <= 1.
  - else if i_ready: o_valid <= 0.
  - else hold.
- Flush wins over a simultaneous accept. The incoming instruction is dropped, and o_ready stays computed from the handshake.
- A held instruction (o_valid & ~i_ready) is never overwritten. o_ready = 0 in that state.

## Timing
- Latency: one cycle from accept to o_valid.
- Throughput: one instruction per cycle while i_ready = 1.
- o_ready is combinational from o_valid and i_ready, with no path from i_valid.
- Reset values (asynchronous assertion, synchronous release):
  - o_valid = 0, o_regWrEnable = 0.
  - o_dataA, o_dataB, o_storeData, o_pc = 0; o_rdAddr = 0.
  - o_op = AluOp_ADD.
- If reset asserts mid-stall, the held instruction is lost and o_valid falls immediately.
- If i_flush and reset are both asserted, reset dominates.

## Configuration
- FORWARDING_EN defined: MEM/WB bypass active, as described in Operation.
- FORWARDING_EN undefined:
  - Resolved rsX = i_rsXData.
  - All i_fwd* ports are ignored and may be left unconnected.
  - Hazards are then resolved by upstream interlock.

## Test plan
- Reset: assert i_reset = 0 mid-stream. Immediately, o_valid = 0, o_regWrEnable = 0 and o_op = AluOp_ADD. After release, the first accept reaches the outputs one cycle later.
- Immediate path: i_op = AluOp_ADD, i_rs1Data = 5, i_selImm = 1, i_imm = 0xFFFFFFFF. Next cycle, o_dataA = 5, o_dataB = 0xFFFFFFFF, o_storeData = i_rs2Data.
- Bypass priority (FORWARDING_EN): i_rs1Addr = 3; MEM bypass (addr 3, 0x11) and WB bypass (addr 3, 0x22) both enabled -> o_dataA = 0x11. With i_rs1Addr = 0 under the same bypasses, o_dataA = i_rs1Data.
- Stall: accept instruction A, then hold i_ready = 0 for 3 cycles while i_valid = 1 with B. Outputs stay equal to A and o_ready = 0. B appears in the cycle after i_ready returns to 1.
- Flush: i_flush = 1 together with an accept while A is held. Next cycle o_valid = 0, and neither A nor the incoming instruction appears.
- Without FORWARDING_EN: bypass addr = rs1 with data 0x11 -> o_dataA = i_rs1Data.
